bcd_to_bin_conv: RTL
====================

// Module: bcd_to_bin_conv
// PURPOSE
//   Sequential decimal-to-binary converter. It is the inverse of the display path's
//   binary-to-digit split.
//   Accepts NUM_DIGITS packed BCD digits (e.g. switch/keypad entry) and produces the
//   binary value using one multiply-by-10 accumulate per clock, MSD first.
//   Has valid/ready handshakes on both sides. Feeds the counter preload path.
//   Flags any non-decimal nibble.
// PARAMETERS
//   NUM_DIGITS  4   number of BCD digits in in_bcd (>=1)
//   OUT_W       14  binary output width; must satisfy 2**OUT_W > 10**NUM_DIGITS - 1
// PORTS
//   clk        in   1              system clock, rising edge
//   reset      in   1              synchronous, active-high reset
//   in_valid   in   1              in_bcd holds a word to convert
//   in_ready   out  1              converter idle, word accepted this cycle if in_valid
//   in_bcd     in   4*NUM_DIGITS   packed BCD; [3:0]=ones, [7:4]=tens, ... MSD at top
//   out_valid  out  1              out_val/out_err hold a finished result
//   out_ready  in   1              consumer takes result this cycle if out_valid
//   out_val    out  OUT_W          binary result; 0 when out_err=1
//   out_err    out  1              at least one nibble of the accepted word was > 9
// BEHAVIOUR
//   Reset (sync, high):
//     - state=IDLE, accumulator=0, digit index=0, err flag=0
//     - in_ready=1, out_valid=0, out_val=0, out_err=0
//     - Reset wins over every other event. Reset mid-CONV or in DONE drops the
//       conversion silently; no result is emitted.
//   FSM IDLE -> CONV -> DONE -> IDLE:
//     IDLE:
//       - in_ready=1.
//       - On edge with in_valid=1: capture in_bcd into shift reg, acc<=0,
//         idx<=NUM_DIGITS-1, err<=0, go CONV.
//     CONV:
//       - in_ready=0; in_valid ignored and in_bcd not sampled.
//       - Each edge: d = nibble[idx]; acc <= (acc<<3)+(acc<<1)+d, truncated to OUT_W;
//         err <= err | (d>9).
//       - After processing idx==0, go DONE. Exactly NUM_DIGITS cycles.
//     DONE:
//       - out_valid=1. out_val=acc when err=0, else 0. out_err=err.
//       - Outputs stable while out_ready=0; hold indefinitely.
//       - On edge with out_ready=1, go IDLE. in_ready is 1 the following cycle.
//         No same-cycle DONE->accept bypass.
//   Latency:
//     - The accept edge is edge 0. out_valid is high after edge NUM_DIGITS;
//       with NUM_DIGITS=4 that is edge 4.
//     - Minimum issue interval is NUM_DIGITS+2 cycles.
//   Width rules:
//     - acc is OUT_W bits. Intermediate *10 is computed at OUT_W+4 bits, then truncated.
//     - No overflow is possible for legal input under the OUT_W constraint.
//     - Illegal nibbles (A-F) still accumulate, but the result is masked to 0.
//   Outputs are registered or decoded from state only. No combinational path from
//   in_* or out_ready to any output.
// TESTING
//   1. in_bcd=16'h1234 held 1 cycle with in_valid, out_ready=1
//      -> out_valid after edge 4; out_val=1234 (0x04D2); out_err=0.
//   2. in_bcd=16'h9999 -> out_val=9999 (0x270F), out_err=0.
//      in_bcd=16'h0000 -> out_val=0, out_err=0.
//   3. in_bcd=16'h12A4 -> out_valid after edge 4; out_err=1; out_val=0.
//      The next word 16'h0042 gives out_val=42 with out_err=0 (err cleared on accept).
//   4. Back-pressure: out_ready=0 for 10 cycles after out_valid
//      -> out_val, out_err and out_valid unchanged.
//      Raise out_ready -> in_ready=1 on the next cycle.
//   5. in_valid held high with new data during CONV/DONE
//      -> ignored; result reflects only the word accepted at the IDLE edge.
//   6. Assert reset at edge 2 of CONV
//      -> next cycle in_ready=1, out_valid=0, out_val=0, out_err=0; no result emitted.
//      A fresh 16'h0007 converts to 7.

Source files
------------

// File: rtl/bcd_to_bin_conv.sv
// ----------------------------------------------------------------------------
// bcd_to_bin_conv
//   Sequential packed-BCD to binary converter. An accepted word is walked one
//   digit per clock, most significant digit first, with a multiply-by-10
//   accumulate. Any nibble above 9 flags the result as erroneous and masks the
//   binary value to zero. Valid/ready handshakes on both sides; every output
//   comes straight from a register.
//
// Ports
//   clk        in   1              system clock, rising edge
//   reset      in   1              synchronous, active-high reset
//   in_valid   in   1              in_bcd holds a word to convert
//   in_ready   out  1              converter idle; word taken this cycle if in_valid
//   in_bcd     in   4*NUM_DIGITS   packed BCD, [3:0]=ones, MSD at the top
//   out_valid  out  1              out_val/out_err hold a finished result
//   out_ready  in   1              consumer takes the result this cycle if out_valid
//   out_val    out  OUT_W          binary result, 0 when out_err=1
//   out_err    out  1              at least one nibble of the word was > 9
// ----------------------------------------------------------------------------
module bcd_to_bin_conv #(
   parameter int NUM_DIGITS = 4,
   parameter int OUT_W      = 14
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [4*NUM_DIGITS-1:0] in_bcd,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [OUT_W-1:0]        out_val,
   output logic                    out_err
);

   localparam int IN_W  = 4 * NUM_DIGITS;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONV = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // A nibble is a legal decimal digit only for values 0..9.
   function automatic logic nibble_illegal(input logic [3:0] nib);
      return (nib > 4'd9);
   endfunction

   state_t               state_r,     state_s;
   logic [IN_W-1:0]      shift_r,     shift_s;
   logic [OUT_W-1:0]     acc_r,       acc_s;
   logic [IDX_W-1:0]     idx_r,       idx_s;
   logic                 err_r,       err_s;
   logic                 in_ready_r,  in_ready_s;
   logic                 out_valid_r, out_valid_s;
   logic [OUT_W-1:0]     out_val_r,   out_val_s;
   logic                 out_err_r,   out_err_s;

   logic [3:0]           digit_s;
   logic [OUT_W+3:0]     acc_x10_s;
   logic [OUT_W-1:0]     acc_step_s;
   logic                 err_step_s;

   // Digit datapath: the word is shifted left so the current digit is always on top.
   always_comb begin
      digit_s    = shift_r[IN_W-1 -: 4];
      acc_x10_s  = ({4'b0000, acc_r} << 4'd3) + ({4'b0000, acc_r} << 4'd1)
                 + {{OUT_W{1'b0}}, digit_s};
      acc_step_s = acc_x10_s[OUT_W-1:0];
      err_step_s = err_r | nibble_illegal(digit_s);
   end

   // Next-state and next-output decode for the IDLE -> CONV -> DONE sequence.
   always_comb begin
      state_s     = state_r;
      shift_s     = shift_r;
      acc_s       = acc_r;
      idx_s       = idx_r;
      err_s       = err_r;
      in_ready_s  = in_ready_r;
      out_valid_s = out_valid_r;
      out_val_s   = out_val_r;
      out_err_s   = out_err_r;

      case (state_r)
         ST_IDLE: begin
            if (in_valid) begin
               state_s    = ST_CONV;
               shift_s    = in_bcd;
               acc_s      = '0;
               idx_s      = IDX_W'(NUM_DIGITS - 1);
               err_s      = 1'b0;
               in_ready_s = 1'b0;
            end else begin
               in_ready_s = 1'b1;
            end
         end

         ST_CONV: begin
            shift_s = shift_r << 4'd4;
            acc_s   = acc_step_s;
            err_s   = err_step_s;
            if (idx_r == '0) begin
               // Last digit: publish the result from the values being written now.
               state_s     = ST_DONE;
               out_valid_s = 1'b1;
               out_err_s   = err_step_s;
               out_val_s   = err_step_s ? '0 : acc_step_s;
            end else begin
               idx_s = idx_r - IDX_W'(1);
            end
         end

         ST_DONE: begin
            if (out_ready) begin
               // in_ready rises only after the handoff edge; no bypass into a new accept.
               state_s     = ST_IDLE;
               in_ready_s  = 1'b1;
               out_valid_s = 1'b0;
               out_val_s   = '0;
               out_err_s   = 1'b0;
            end else begin
               out_valid_s = 1'b1;
            end
         end

         default: begin
            state_s     = ST_IDLE;
            in_ready_s  = 1'b1;
            out_valid_s = 1'b0;
            out_val_s   = '0;
            out_err_s   = 1'b0;
         end
      endcase
   end

   // State and output registers; reset abandons any conversion in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         shift_r     <= '0;
         acc_r       <= '0;
         idx_r       <= '0;
         err_r       <= 1'b0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         out_val_r   <= '0;
         out_err_r   <= 1'b0;
      end else begin
         state_r     <= state_s;
         shift_r     <= shift_s;
         acc_r       <= acc_s;
         idx_r       <= idx_s;
         err_r       <= err_s;
         in_ready_r  <= in_ready_s;
         out_valid_r <= out_valid_s;
         out_val_r   <= out_val_s;
         out_err_r   <= out_err_s;
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_val   = out_val_r;
   assign out_err   = out_err_r;

endmodule
